// File: rtl/instruction_encoder.sv
// instruction_encoder: packs MIPS R/I/J fields into 32-bit words and streams them out through a DEPTH-entry FIFO.
// Latency: a tuple accepted at edge N is visible at the output after edge N if the FIFO was empty; in_ready = !full, so a full FIFO never passes through.
// Optional legality check (illegal tuples are dropped and flagged on err) is enabled by defining INSTR_ENCODER_FIELD_CHECK_EN.

module instr_enc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push_rdy = !full;
    assign pop_vld  = !empty;
    assign push     = push_vld && !full;
    assign pop      = pop_rdy && !empty;
    assign pop_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
endmodule

module instruction_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       format,
    input  logic [5:0]       opcode,
    input  logic [4:0]       RS,
    input  logic [4:0]       RT,
    input  logic [4:0]       RD,
    input  logic [4:0]       shamt,
    input  logic [5:0]       funct,
    input  logic [15:0]      IAddress,
    input  logic [25:0]      JAddress,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instruction,
    output logic [CNT_W-1:0] emit_count,
    output logic             err,
    input  logic             err_clr
);
    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("instruction_encoder: DEPTH must be a power of 2 and >= 2");
    end

    logic [31:0]      packed_word;
    logic             legal;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] emit_count_q, emit_count_d;

    always_comb begin
        packed_word = 32'h0000_0000;
        case (format)
            FMT_R:   packed_word = {opcode, RS, RT, RD, shamt, funct};
            FMT_I:   packed_word = {opcode, RS, RT, IAddress};
            FMT_J:   packed_word = {opcode, JAddress};
            default: packed_word = 32'h0000_0000;
        endcase
    end

`ifdef INSTR_ENCODER_FIELD_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        legal = 1'b0;
        case (format)
            FMT_R:   legal = (opcode == 6'd0);
            FMT_J:   legal = (opcode == 6'd2) || (opcode == 6'd3);
            FMT_I:   legal = !((opcode == 6'd0) || (opcode == 6'd2) || (opcode == 6'd3));
            default: legal = 1'b0;
        endcase
    end

    // A new illegal accept overrides a clear in the same cycle.
    always_comb begin
        err_d = err_q;
        if (err_clr)           err_d = 1'b0;
        if (accept && !legal)  err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_err_clr;

    assign legal          = 1'b1;
    assign err            = 1'b0;
    assign unused_err_clr = err_clr;
`endif

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    instr_enc_fifo #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (accept && legal),
        .push_rdy (in_ready),
        .push_dat (packed_word),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (instruction)
    );

    always_comb begin
        emit_count_d = emit_count_q;
        if (pop) emit_count_d = emit_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) emit_count_q <= '0;
        else        emit_count_q <= emit_count_d;
    end

    assign emit_count = emit_count_q;
endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Packs separate MIPS instruction fields into a 32-bit instruction word. This is the inverse of the instruction-field decoder.
- Accepts one field tuple per handshake and buffers the encoded words in a small FIFO.
- Emits words over a valid/ready stream toward instruction memory or a NoC injection port.
- Keeps a count of words emitted.

Parameters:
- DEPTH, 4, output FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  field tuple valid.
- in_ready  output  1  encoder can accept a tuple.
- format  input  2  0=R, 1=I, 2=J, 3=reserved.
- opcode  input  6  bits [31:26].
- RS  input  5  R/I bits [25:21].
- RT  input  5  R/I bits [20:16].
- RD  input  5  R bits [15:11].
- shamt  input  5  R bits [10:6].
- funct  input  6  R bits [5:0].
- IAddress  input  16  I immediate, bits [15:0].
- JAddress  input  26  J target, bits [25:0].
- out_valid  output  1  instruction word available.
- out_ready  input  1  consumer accepts the word.
- instruction  output  32  encoded word (head of FIFO).
- emit_count  output  CNT_W  words popped since reset.
- err  output  1  sticky illegal-tuple flag (feature only; tied 0 otherwise).
- err_clr  input  1  clears err (ignored without the feature).

Behaviour:
- Reset (asynchronous, rst_n low): FIFO empty, out_valid=0, instruction=0, emit_count=0, err=0, in_ready=1.
- Reset mid-operation discards all buffered words. Nothing is emitted while rst_n is low.
- Accept rule: a tuple is accepted when in_valid && in_ready on a rising edge.
  - in_ready = !full. It is registered-state derived and never depends on out_ready, so there is no pass-through when full.
- Packing is combinational from the inputs and written into the FIFO on accept:
  - R: {opcode, RS, RT, RD, shamt, funct}.
  - I: {opcode, RS, RT, IAddress}.
  - J: {opcode, JAddress}.
  - reserved: 32'h00000000 (NOP).
  - Fields that the selected format does not use are ignored.
- Latency: a tuple accepted at edge N gives out_valid=1 and instruction=the packed word after edge N, provided the FIFO was empty.
- Ordering is strict FIFO.
- Pop rule: a word is popped on out_valid && out_ready. emit_count increments by 1 on each pop and wraps modulo 2^CNT_W.
- instruction holds the head entry while out_valid=1, and is stable until popped. It reads 0 when empty.
- Simultaneous push and pop:
  - When not full, both occur and occupancy is unchanged.
  - When empty, the push occurs and the pop cannot (out_valid=0).
- Pointers: log2(DEPTH)+1 bits, wrap naturally.
  - full when pointer MSBs differ and lower bits are equal.
  - empty when the pointers are equal.
- out_ready while empty has no effect.
- in_valid while full stalls (in_ready=0). The producer must hold its fields stable until accepted.

Optional Feature:
- Macro: INSTR_ENCODER_FIELD_CHECK_EN.
- Defined: each accepted tuple is checked.
  - R requires opcode==0.
  - J requires opcode==2 or 3.
  - I requires opcode not in {0,2,3}.
  - reserved format is always illegal.
  - An illegal tuple is still accepted (handshake completes) but is dropped, not written to the FIFO.
  - err is set at that edge and stays set until err_clr=1, which clears it at the next edge.
  - If err_clr and a new illegal accept fall in the same cycle, set wins.
- Not defined: no checks. Every tuple is packed as specified; reserved gives 32'h00000000. err is tied to 0 and err_clr is unused.

Test Plan:
- R-type: tuple R, opcode 0, RS 9, RT 10, RD 8, shamt 0, funct 0x20, out_ready=1 -> instruction=0x012A4020 one cycle later; emit_count=1.
- I and J back-to-back:
  - Tuples I (opcode 8, RS 9, RT 8, IAddress 5) then J (opcode 2, JAddress 0x0100000), each one cycle.
  - Required: words 0x21280005 then 0x08100000, in order.
- Fill and backpressure: out_ready=0, push 5 tuples with DEPTH=4 -> in_ready=0 after 4th accept, 5th held. Raise out_ready -> 5 words emitted in order, emit_count=5.
- Simultaneous push/pop at occupancy 2 -> occupancy stays 2, no word lost or duplicated.
- Reset mid-stream: 3 words buffered, pulse rst_n low asynchronously -> out_valid=0, emit_count=0, in_ready=1 immediately.
- Field check (macro defined): R tuple with opcode 8 -> accepted, no output word, err=1; err_clr pulse -> err=0. Without the macro, the same tuple yields word 0x2000_0000 plus other fields.
